// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_pkg;

    localparam int N_VARS_DEF = 7;
    localparam int TT_W       = 2 ** N_VARS_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ones-count needs one bit more than the index so an all-ones table fits.
    function automatic int ones_w(input int n_vars);
        return n_vars + 1;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Function-block drive/sample signals plus the truth-table result port.
// Latency: n/a (wiring only).
// Backpressure: tt_valid is held by the master until tt_ready is seen.
interface tt_sweep_capture_if #(
    parameter int N_VARS = 7
);
    localparam int TBL_W = 2 ** N_VARS;

    logic [N_VARS-1:0]                  x_drive;
    logic                               x_vld;
    logic                               f_in;
    logic [TBL_W-1:0]                   tt;
    logic [tt_pkg::ones_w(N_VARS)-1:0]  tt_ones;
    logic                               tt_valid;
    logic                               tt_ready;

    modport master (
        output x_drive, x_vld, tt, tt_ones, tt_valid,
        input  f_in, tt_ready
    );

    modport slave (
        input  x_drive, x_vld, tt, tt_ones, tt_valid,
        output f_in, tt_ready
    );

endinterface

// File: rtl/tt_lat_pipe.sv
// Tracks each issued vector (valid + index) across the function block's latency.
// Latency: EVAL_LAT cycles; combinational pass-through when EVAL_LAT = 0.
// Backpressure: none; the sweep never stalls, so the line shifts every cycle.
module tt_lat_pipe #(
    parameter int N_VARS   = 7,
    parameter int EVAL_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [N_VARS-1:0] in_idx,
    output logic              out_vld,
    output logic [N_VARS-1:0] out_idx
);

    generate
        if (EVAL_LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_vld = in_vld;
            assign out_idx = in_idx;
        end else begin : g_pipe
            logic [EVAL_LAT-1:0] vld_sr;
            logic [N_VARS-1:0]   idx_sr [EVAL_LAT];

            // Shift valid and index together so the capture side knows which bit f_in belongs to.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                    for (int i = 0; i < EVAL_LAT; i++) begin
                        idx_sr[i] <= '0;
                    end
                end else begin
                    vld_sr[0] <= in_vld;
                    idx_sr[0] <= in_idx;
                    for (int i = 1; i < EVAL_LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                        idx_sr[i] <= idx_sr[i-1];
                    end
                end
            end

            assign out_vld = vld_sr[EVAL_LAT-1];
            assign out_idx = idx_sr[EVAL_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2^N_VARS input vectors into a function block and captures its truth table + ones-count.
// Latency: tt_valid first high 2^N_VARS + EVAL_LAT + 1 cycles after start is sampled.
// Backpressure: result held in DONE until tt_ready; start ignored unless IDLE.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int N_VARS   = N_VARS_DEF,
    parameter int EVAL_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    tt_sweep_capture_if.master bus
);

    localparam int TBL_W  = 2 ** N_VARS;
    localparam int ONES_W = ones_w(N_VARS);
    localparam int DRN_W  = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

    localparam logic [N_VARS-1:0] LAST_IDX = N_VARS'(TBL_W - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'((EVAL_LAT > 0) ? EVAL_LAT - 1 : 0);

    state_t             state;
    state_t             state_nxt;
    logic [N_VARS-1:0]  issue_cnt;
    logic [DRN_W-1:0]   drain_cnt;
    logic [TBL_W-1:0]   tt_q;
    logic [ONES_W-1:0]  ones_q;
    logic               start_acc;
    logic               issue_last;
    logic               x_vld;
    logic               cap_vld;
    logic [N_VARS-1:0]  cap_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE, so DONE-cycle starts are dropped.
    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    start_acc = 1'b1;
                end
            end
            ISSUE: begin
                if (issue_cnt == LAST_IDX) begin
                    issue_last = 1'b1;
                    state_nxt  = (EVAL_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.tt_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue counter doubles as x_drive; it stops at the last index and holds through DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (start_acc) begin
            issue_cnt <= '0;
        end else if ((state == ISSUE) && !issue_last) begin
            issue_cnt <= issue_cnt + N_VARS'(1);
        end
    end

    // Drain counter runs only in DRAIN, giving exactly EVAL_LAT cycles for in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
        end
    end

    assign x_vld = (state == ISSUE);

    tt_lat_pipe #(
        .N_VARS   (N_VARS),
        .EVAL_LAT (EVAL_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (x_vld),
        .in_idx  (issue_cnt),
        .out_vld (cap_vld),
        .out_idx (cap_idx)
    );

    // Table/ones accumulation; cleared as a new sweep is accepted, otherwise held after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q   <= '0;
            ones_q <= '0;
        end else if (start_acc) begin
            tt_q   <= '0;
            ones_q <= '0;
        end else if (cap_vld) begin
            tt_q[cap_idx] <= bus.f_in;
            ones_q        <= ones_q + ONES_W'(bus.f_in);
        end
    end

    assign bus.x_drive  = issue_cnt;
    assign bus.x_vld    = x_vld;
    assign bus.tt       = tt_q;
    assign bus.tt_ones  = ones_q;
    assign bus.tt_valid = (state == DONE);
    assign busy         = (state == ISSUE) || (state == DRAIN);

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Initiator side of the 7-input function interface. Sweeps every input vector into a function block (combinational or pipelined) and samples its single-bit output.
- Assembles the 2^N_VARS-bit truth table of that function and a ones-count, then presents both on a valid/ready output port.
- Used by the classification flow to produce the hex truth-table signature of a function network. It is the reader for the function evaluators.

Parameters:
- N_VARS, 7, number of function inputs; truth table width TT_W = 2**N_VARS.
- EVAL_LAT, 0, cycles from x_drive valid to the matching f_in being valid (0 = combinational DUT).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a sweep when idle
- busy  out  1  high from the cycle after start is accepted until tt_valid rises
- x_drive  out  N_VARS  input vector to the function block; bit k drives xk
- x_vld  out  1  x_drive carries a live vector this cycle
- f_in  in  1  function output for the vector issued EVAL_LAT cycles earlier
- tt  out  TT_W  truth table; tt[i] = f(x) where i = {x(N-1)..x0}, x0 = LSB
- tt_ones  out  N_VARS+1  number of 1 bits in tt
- tt_valid  out  1  tt/tt_ones valid; held until accepted
- tt_ready  in  1  consumer accepts when tt_valid & tt_ready

Behaviour:
- Reset values:
  - busy = 0, x_vld = 0, x_drive = 0, tt = 0, tt_ones = 0, tt_valid = 0.
  - FSM = IDLE; issue counter, capture counter and the EVAL_LAT delay line are cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start = 1 moves to ISSUE.
  - On entry to ISSUE, tt and tt_ones are cleared.
- ISSUE:
  - One vector per cycle. x_drive = issue counter (0, 1, ..., TT_W-1), with x_vld = 1.
  - After vector TT_W-1 is issued: go to DRAIN if EVAL_LAT > 0, else DONE.
- Capture path:
  - A valid/index delay line of depth EVAL_LAT tracks each vector.
  - When a tracked valid emerges, f_in is written to tt[index] and tt_ones increments by f_in.
  - With EVAL_LAT = 0, f_in is captured in the same cycle the vector is driven.
- DRAIN: lasts exactly EVAL_LAT cycles, with x_vld = 0 and x_drive held at its last value; then go to DONE.
- DONE:
  - tt_valid = 1; tt and tt_ones are stable.
  - When tt_valid & tt_ready: go to IDLE and drop tt_valid next cycle. tt and tt_ones keep their value until the next sweep starts.
- Latency:
  - start sampled in cycle 0; vectors issued in cycles 1..TT_W.
  - tt_valid first high in cycle TT_W + EVAL_LAT + 1 (129 for the defaults).
- start while busy or in DONE: ignored. No queuing, and no effect on the current sweep.
- start in the same cycle as the DONE handshake: ignored. A new start must arrive while in IDLE.
- f_in is don't-care on cycles with no tracked valid.
- rst mid-sweep: the next cycle is in reset state and any partial table is discarded.
- tt_ones width N_VARS+1 holds TT_W exactly (all-ones function → 128). It never wraps.
- Counter wrap: the issue counter is N_VARS bits; terminal count is detected at TT_W-1, never by overflow.
- Signature convention: hex of tt, MSB nibble first, is the function's file-name signature.

Decomposition:
- Shared package (tt_pkg):
  - N_VARS_DEF = 7
  - localparam TT_W
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE}
  - Helper function for the ones-count width
- One sub-module: tt_lat_pipe.
  - Parameterised EVAL_LAT-deep valid + N_VARS-bit index shift register.
  - Passes through combinationally when EVAL_LAT = 0; cleared by rst.

Test Plan:
- DUT f = x0, EVAL_LAT = 0, start pulse → tt_valid at cycle 129; tt = 0xAAAA_..._AAAA (32 hex A); tt_ones = 64.
- DUT f = maj(x0,x1,x2), EVAL_LAT = 0 → tt = 0xE8 repeated 16 times; tt_ones = 64.
- DUT f = 1 behind a 2-stage register, EVAL_LAT = 2 → tt_valid at cycle 131; tt = all ones; tt_ones = 128; x_vld high exactly 128 cycles.
- Backpressure: tt_ready low for 10 cycles after tt_valid, with start pulsed during the hold → tt/tt_valid stable and start ignored. Raise tt_ready → tt_valid low next cycle, FSM in IDLE.
- rst asserted when x_drive = 50 → next cycle busy = 0, x_vld = 0, tt = 0. A fresh start with f = x6 then gives tt = upper 64 bits ones, lower 64 bits zero; tt_ones = 64.
- Zero function, start held high for 3 cycles → exactly one sweep runs; tt = 0, tt_ones = 0.
